// File: rtl/xmit_pkg.sv
// Shared definitions for the transmitter arbiter and its round-robin picker.
package xmit_pkg;

  localparam int MAX_REQ    = 4;
  localparam int HOLD_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_GUARD = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/xmit_arbiter_rr_pick.sv
// Combinational round-robin picker: scans last_owner+1, last_owner+2, ...
// modulo NUM_REQ and returns the first asserting index.
module rr_pick
  import xmit_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(MAX_REQ)-1:0] last_owner,
  output logic [$clog2(MAX_REQ)-1:0] grant,
  output logic                       any
);

  // Walk the scan order backwards so the earliest candidate overwrites later ones.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[(int'(last_owner) + off) % NUM_REQ]) begin
        grant = $clog2(MAX_REQ)'((int'(last_owner) + off) % NUM_REQ);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xmit_arbiter.sv
// Shares the host transmitter between several word sources, one word per
// grant, with an optional per-requester burst lock.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no transfer; grant round-robin when transmitter is free
//   ST_SEND  | send strobe and ack pulse for the latched word
//   ST_GUARD | one cycle ignoring busy (transmitter's busy lags a cycle)
//   ST_DRAIN | wait for the transmitter to go idle
//   ST_HOLD  | burst lock: only the current owner may issue the next word
module xmit_arbiter
  import xmit_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int WIDTH        = 32,
  parameter int HOLD_TIMEOUT = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         dataOutput,
  output logic                     send,
  input  logic                     busy,
  output logic [1:0]               owner,
  output logic                     active
);

  localparam logic [HOLD_CNT_W-1:0] TIMEOUT_LAST =
    (HOLD_TIMEOUT == 0) ? '0 : HOLD_CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic TIMEOUT_EN = (HOLD_TIMEOUT != 0);

  state_t                 state, state_n;
  logic [1:0]             owner_n;
  logic [1:0]             last_owner, last_owner_n;
  logic [WIDTH-1:0]       data_n;
  logic [HOLD_CNT_W-1:0]  hold_cnt, hold_cnt_n;
  logic [MAX_REQ-1:0]     req_ext, lock_ext;
  logic [WIDTH-1:0]       words [MAX_REQ];
  logic [1:0]             pick;
  logic                   pick_any;

  assign req_ext  = MAX_REQ'(req);
  assign lock_ext = MAX_REQ'(lock);

  // Unpack requester words; slots beyond NUM_REQ read as zero and are never granted.
  always_comb begin
    for (int i = 0; i < MAX_REQ; i++) words[i] = '0;
    for (int i = 0; i < NUM_REQ; i++) words[i] = reqData[i*WIDTH +: WIDTH];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .grant      (pick),
    .any        (pick_any)
  );

  // Strobes are decoded straight from the state register, so reset clears them at once.
  assign send   = (state == ST_SEND);
  assign ack    = send ? NUM_REQ'(MAX_REQ'(1) << owner) : '0;
  assign active = (state != ST_IDLE);

  // Next-state, grant, data latch and hold-counter decisions.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    data_n       = dataOutput;
    hold_cnt_n   = hold_cnt;
    unique case (state)
      ST_IDLE: begin
        if (!busy && pick_any) begin
          owner_n = pick;
          data_n  = words[pick];
          state_n = ST_SEND;
        end
      end
      ST_SEND:  state_n = ST_GUARD;
      ST_GUARD: state_n = ST_DRAIN;
      ST_DRAIN: begin
        if (!busy) begin
          if (lock_ext[owner]) begin
            state_n    = ST_HOLD;
            hold_cnt_n = '0;
          end else begin
            state_n      = ST_IDLE;
            last_owner_n = owner;
          end
        end
      end
      ST_HOLD: begin
        if (req_ext[owner]) begin
          data_n     = words[owner];
          state_n    = ST_SEND;
          hold_cnt_n = '0;
        end else if (!lock_ext[owner]) begin
          state_n      = ST_IDLE;
          last_owner_n = owner;
        end else if (TIMEOUT_EN && (hold_cnt == TIMEOUT_LAST)) begin
          state_n      = ST_IDLE;
          last_owner_n = owner;
        end else if (hold_cnt != '1) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= 2'(NUM_REQ - 1);
      dataOutput <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      dataOutput <= data_n;
      hold_cnt   <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_xmit_arbiter.sv
// Directed bench for xmit_arbiter (two requesters, hold timeout of 8 cycles).
module tb_xmit_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, lock, ack, owner;
  logic [63:0] reqData;
  logic [31:0] dataOutput;
  logic        send, busy, active;

  int n_cmp = 0;
  int n_err = 0;

  xmit_arbiter #(.NUM_REQ(2), .WIDTH(32), .HOLD_TIMEOUT(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .lock       (lock),
    .reqData    (reqData),
    .ack        (ack),
    .dataOutput (dataOutput),
    .send       (send),
    .busy       (busy),
    .owner      (owner),
    .active     (active)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int busy_left;
    int n_send;
    int last_send;
    logic [1:0] exp_owner;

    reset = 1'b1; req = '0; lock = '0; reqData = '0; busy = 1'b0;
    tick(); tick();
    chk("rst_send", send, 0);
    chk("rst_ack", ack, 0);
    chk("rst_data", dataOutput, 0);
    chk("rst_owner", owner, 0);
    chk("rst_active", active, 0);

    // single word, one-cycle latency
    reset = 1'b0;
    req = 2'b01; reqData[31:0] = 32'h11223344;
    tick();
    chk("t1_send", send, 1);
    chk("t1_ack", ack, 2'b01);
    chk("t1_data", dataOutput, 32'h11223344);
    chk("t1_owner", owner, 0);
    chk("t1_active", active, 1);
    req = 2'b00;
    tick();
    chk("t1_send_pulse", send, 0);
    chk("t1_ack_pulse", ack, 0);
    tick(); tick();
    chk("t1_idle", active, 0);
    chk("t1_data_keep", dataOutput, 32'h11223344);

    // both requesters held, transmitter busy for 3 cycles per word
    reset = 1'b1; tick(); reset = 1'b0;
    req = 2'b11; reqData = {32'hD1, 32'hD0};
    busy_left = 0; n_send = 0; last_send = -10; exp_owner = 2'd0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (send) begin
        chk("t2_owner", owner, exp_owner);
        chk("t2_ack", ack, (exp_owner == 2'd0) ? 2'b01 : 2'b10);
        chk("t2_data", dataOutput, (exp_owner == 2'd0) ? 32'hD0 : 32'hD1);
        chk("t2_spacing_ok", (k - last_send) >= 4, 1);
        last_send = k; n_send++; exp_owner = ~exp_owner & 2'b01;
        busy_left = 3;
      end else begin
        chk("t2_ack_idle", ack, 0);
      end
      busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
    chk("t2_num_sends", n_send, 4);
    req = 2'b00; busy = 1'b0;

    // burst lock from requester 1 while requester 0 waits
    req = 2'b10; lock = 2'b10; reqData = {32'hA0, 32'hB0};
    for (int k = 1; k <= 13; k++) begin
      tick();
      case (k)
        1, 5, 9: begin
          chk("t3_send", send, 1);
          chk("t3_ack", ack, 2'b10);
          chk("t3_owner", owner, 1);
          chk("t3_data", dataOutput, (k == 1) ? 32'hA0 : (k == 5) ? 32'hA1 : 32'hA2);
        end
        13: begin
          chk("t3_r0_send", send, 1);
          chk("t3_r0_ack", ack, 2'b01);
          chk("t3_r0_data", dataOutput, 32'hB0);
        end
        default: begin
          chk("t3_gap_send", send, 0);
          chk("t3_gap_ack", ack, 0);
        end
      endcase
      case (k)
        1: begin req = 2'b11; reqData[63:32] = 32'hA1; end
        5: reqData[63:32] = 32'hA2;
        9: begin req = 2'b01; lock = 2'b00; end
        13: req = 2'b00;
        default: ;
      endcase
    end
    tick(); tick(); tick();
    chk("t3_idle", active, 0);

    // hold timeout: lock[0] held with no further words, requester 1 pending
    req = 2'b01; lock = 2'b01; reqData = {32'hE1, 32'hC0};
    tick();
    chk("t4_send", send, 1);
    chk("t4_owner", owner, 0);
    chk("t4_data", dataOutput, 32'hC0);
    req = 2'b10;
    for (int k = 18; k <= 27; k++) begin
      tick();
      chk("t4_hold_send", send, 0);
      chk("t4_hold_active", active, 1);
    end
    tick();
    chk("t4_released", active, 0);
    chk("t4_released_send", send, 0);
    tick();
    chk("t4_r1_send", send, 1);
    chk("t4_r1_ack", ack, 2'b10);
    chk("t4_r1_owner", owner, 1);
    chk("t4_r1_data", dataOutput, 32'hE1);
    req = 2'b00; lock = 2'b00;
    tick(); tick(); tick();
    chk("t4_idle", active, 0);

    // transmitter busy for 20 cycles blocks the grant
    busy = 1'b1; req = 2'b10; reqData[63:32] = 32'hF1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t5_busy_send", send, 0);
    end
    busy = 1'b0;
    tick();
    chk("t5_send", send, 1);
    chk("t5_owner", owner, 1);
    chk("t5_data", dataOutput, 32'hF1);
    req = 2'b00;
    tick(); tick(); tick();

    // reset during GUARD with lock held
    req = 2'b01; lock = 2'b01; reqData = {32'h77, 32'h55};
    tick();
    chk("t6_send", send, 1);
    req = 2'b00;
    tick();
    chk("t6_guard_active", active, 1);
    chk("t6_guard_send", send, 0);
    reset = 1'b1;
    tick();
    chk("t6_rst_send", send, 0);
    chk("t6_rst_active", active, 0);
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_owner", owner, 0);
    chk("t6_rst_data", dataOutput, 0);
    reset = 1'b0; lock = 2'b00; req = 2'b11; reqData = {32'h77, 32'h66};
    tick();
    chk("t6_first_send", send, 1);
    chk("t6_first_ack", ack, 2'b01);
    chk("t6_first_owner", owner, 0);
    chk("t6_first_data", dataOutput, 32'h66);
    req = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
